// File: rtl/router_pkg.sv
// Shared router definitions: widths, the illegal destination code, transmitter states
// and the header packing helper.
package router_pkg;

  localparam int DATA_W  = 8;
  localparam int LEN_W   = 6;
  localparam int ADDR_W  = 2;
  localparam int MAX_LEN = 63;

  localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    TX_IDLE    = 3'd0,
    TX_LOAD    = 3'd1,
    TX_HEADER  = 3'd2,
    TX_PAYLOAD = 3'd3,
    TX_PARITY  = 3'd4,
    TX_GAP     = 3'd5
  } tx_state_e;

  // The header byte carries the payload length above the destination port.
  function automatic logic [DATA_W-1:0] make_header(input logic [LEN_W-1:0]  len,
                                                    input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_pkt_buf.sv
// Payload store for one packet: written byte by byte while loading,
// read combinationally by the beat index while transmitting.
module router_pkt_buf
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [LEN_W-1:0]  wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [LEN_W-1:0]  rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [0:MAX_LEN];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter feeding the 1x3 router: buffers a whole payload, then sends
// header, payload and parity, holding each beat while the router is busy.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_corrupt,
  output logic              cmd_err,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic [DATA_W-1:0] pl_data,
  input  logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              pkt_valid,
  output logic              tx_done
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  tx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic              corrupt_q, corrupt_d;
  logic [DATA_W-1:0] par_q, par_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              pkt_valid_q, pkt_valid_d;
  logic              tx_done_q, tx_done_d;
  logic              cmd_err_q, cmd_err_d;
  logic [3:0]        gap_q, gap_d;

  logic              buf_wr_en;
  logic [DATA_W-1:0] buf_rd_data;
  logic [DATA_W-1:0] parity_byte;

  assign cmd_ready   = (state_q == TX_IDLE) && !rst;
  assign pl_ready    = (state_q == TX_LOAD) && (cnt_q < len_q) && !rst;
  assign buf_wr_en   = pl_valid && pl_ready;
  assign parity_byte = par_q ^ {DATA_W{corrupt_q}};

  assign data_out  = data_out_q;
  assign pkt_valid = pkt_valid_q;
  assign tx_done   = tx_done_q;
  assign cmd_err   = cmd_err_q;

  router_pkt_buf u_buf (
    .clk       (clk),
    .wr_en_i   (buf_wr_en),
    .wr_addr_i (cnt_q),
    .wr_data_i (pl_data),
    .rd_addr_i (idx_q),
    .rd_data_o (buf_rd_data)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    corrupt_d   = corrupt_q;
    par_d       = par_q;
    data_out_d  = data_out_q;
    pkt_valid_d = pkt_valid_q;
    tx_done_d   = 1'b0;
    cmd_err_d   = 1'b0;
    gap_d       = gap_q;

    case (state_q)
      TX_IDLE: begin
        if (cmd_valid) begin
          if (cmd_addr == ADDR_ILLEGAL) begin
            cmd_err_d = 1'b1;
          end else begin
            addr_d    = cmd_addr;
            len_d     = cmd_len;
            corrupt_d = cmd_corrupt;
            cnt_d     = '0;
            par_d     = make_header(cmd_len, cmd_addr);
            state_d   = TX_LOAD;
          end
        end
      end
      TX_LOAD: begin
        if (cnt_q == len_q) begin
          data_out_d  = make_header(len_q, addr_q);
          pkt_valid_d = 1'b1;
          idx_d       = '0;
          state_d     = TX_HEADER;
        end else if (buf_wr_en) begin
          par_d = par_q ^ pl_data;
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      // idx_q always points at the next buffer entry to put on the wire.
      TX_HEADER, TX_PAYLOAD: begin
        if (!busy) begin
          if (idx_q < len_q) begin
            data_out_d = buf_rd_data;
            idx_d      = idx_q + LEN_W'(1);
            state_d    = TX_PAYLOAD;
          end else begin
            data_out_d  = parity_byte;
            pkt_valid_d = 1'b0;
            state_d     = TX_PARITY;
          end
        end
      end
      TX_PARITY: begin
        if (!busy) begin
          data_out_d = '0;
          tx_done_d  = 1'b1;
          gap_d      = '0;
          state_d    = TX_GAP;
        end
      end
      TX_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = TX_IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= TX_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      corrupt_q   <= 1'b0;
      par_q       <= '0;
      data_out_q  <= '0;
      pkt_valid_q <= 1'b0;
      tx_done_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      corrupt_q   <= corrupt_d;
      par_q       <= par_d;
      data_out_q  <= data_out_d;
      pkt_valid_q <= pkt_valid_d;
      tx_done_q   <= tx_done_d;
      cmd_err_q   <= cmd_err_d;
      gap_q       <= gap_d;
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: each packet is loaded, then its byte stream is
// compared beat by beat against headers and parities worked out here.
module tb_router_pkt_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_addr;
  logic [5:0] cmd_len;
  logic       cmd_corrupt;
  logic       cmd_err;
  logic       pl_valid;
  logic       pl_ready;
  logic [7:0] pl_data;
  logic       busy;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       tx_done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] bytes_q [0:63];

  always #5 clk = ~clk;

  router_pkt_tx #(.GAP_CYCLES(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .cmd_corrupt (cmd_corrupt),
    .cmd_err     (cmd_err),
    .pl_valid    (pl_valid),
    .pl_ready    (pl_ready),
    .pl_data     (pl_data),
    .busy        (busy),
    .data_out    (data_out),
    .pkt_valid   (pkt_valid),
    .tx_done     (tx_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_bytes(input int seed);
    for (int k = 0; k < 64; k++) begin
      bytes_q[k] = 8'((k * 37 + seed * 11 + 5) ^ (k << 3));
    end
  endtask

  // busy_beat/rst_beat index the wire stream: 0 = header, 1..len = payload, len+1 = parity.
  task automatic run_pkt(input string tag, input logic [1:0] addr, input int len,
                         input logic corrupt, input logic [7:0] exp_hdr,
                         input int busy_beat, input int busy_len, input int rst_beat);
    logic [7:0] exp_beats [0:65];
    logic [7:0] par;
    int b, stall, vcount, cyc, exp_v, waitc;

    waitc = 0;
    while (!cmd_ready && waitc < 20) begin
      tick();
      waitc++;
    end
    check_eq({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);

    par = exp_hdr;
    exp_beats[0] = exp_hdr;
    for (int k = 0; k < len; k++) begin
      exp_beats[k+1] = bytes_q[k];
      par = par ^ bytes_q[k];
    end
    exp_beats[len+1] = corrupt ? ~par : par;

    cmd_valid   = 1'b1;
    cmd_addr    = addr;
    cmd_len     = 6'(len);
    cmd_corrupt = corrupt;
    tick();
    cmd_valid   = 1'b0;
    cmd_addr    = 2'd0;
    cmd_len     = 6'd0;
    cmd_corrupt = 1'b0;

    for (int k = 0; k < len; k++) begin
      pl_valid = 1'b1;
      pl_data  = bytes_q[k];
      check_eq({tag, "_pl_ready_on"}, 32'(pl_ready), 32'd1);
      tick();
    end
    pl_valid = 1'b0;
    pl_data  = 8'd0;
    check_eq({tag, "_pl_ready_off"}, 32'(pl_ready), 32'd0);
    tick();

    b = 0; stall = busy_len; vcount = 0; cyc = 0;
    while (b < len + 2 && cyc < len + 40) begin
      if (b == rst_beat) begin
        rst = 1'b1;
        #1;
        check_eq({tag, "_rst_cmd_ready"}, 32'(cmd_ready), 32'd0);
        tick();
        rst = 1'b0;
        check_eq({tag, "_rst_pkt_valid"}, 32'(pkt_valid), 32'd0);
        check_eq({tag, "_rst_data_out"}, 32'(data_out), 32'd0);
        check_eq({tag, "_rst_tx_done"}, 32'(tx_done), 32'd0);
        #1;
        check_eq({tag, "_rst_idle"}, 32'(cmd_ready), 32'd1);
        $display("pkt %s addr=%0d len=%0d aborted by reset at beat %0d", tag, addr, len, b);
        return;
      end
      check_eq($sformatf("%s_beat%0d", tag, b), 32'(data_out), 32'(exp_beats[b]));
      check_eq($sformatf("%s_valid%0d", tag, b), 32'(pkt_valid), 32'(b <= len));
      check_eq($sformatf("%s_nodone%0d", tag, b), 32'(tx_done), 32'd0);
      if (pkt_valid) vcount++;
      if (b == busy_beat && stall > 0) begin
        busy = 1'b1;
        stall--;
      end else begin
        busy = 1'b0;
        b++;
      end
      tick();
      cyc++;
    end
    busy = 1'b0;
    check_eq({tag, "_beats"}, 32'(b), 32'(len + 2));
    exp_v = len + 1 + ((busy_beat >= 0 && busy_beat <= len) ? busy_len : 0);
    check_eq({tag, "_valid_cycles"}, 32'(vcount), 32'(exp_v));
    check_eq({tag, "_tx_done"}, 32'(tx_done), 32'd1);
    check_eq({tag, "_gap_valid"}, 32'(pkt_valid), 32'd0);
    check_eq({tag, "_gap_data"}, 32'(data_out), 32'd0);
    check_eq({tag, "_gap_cmd_ready"}, 32'(cmd_ready), 32'd0);
    tick();
    check_eq({tag, "_tx_done_pulse"}, 32'(tx_done), 32'd0);
    check_eq({tag, "_idle_cmd_ready"}, 32'(cmd_ready), 32'd1);
    $display("pkt %s addr=%0d len=%0d corrupt=%0d parity=0x%02h checks=%0d failures=%0d",
             tag, addr, len, corrupt, exp_beats[len+1], checks, failures);
  endtask

  initial begin
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_addr    = 2'd0;
    cmd_len     = 6'd0;
    cmd_corrupt = 1'b0;
    pl_valid    = 1'b0;
    pl_data     = 8'd0;
    busy        = 1'b0;

    tick();
    tick();
    check_eq("reset_data_out", 32'(data_out), 32'd0);
    check_eq("reset_pkt_valid", 32'(pkt_valid), 32'd0);
    check_eq("reset_tx_done", 32'(tx_done), 32'd0);
    check_eq("reset_cmd_err", 32'(cmd_err), 32'd0);
    check_eq("reset_pl_ready", 32'(pl_ready), 32'd0);
    check_eq("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    $display("reset done checks=%0d failures=%0d", checks, failures);
    tick();

    fill_bytes(1);
    run_pkt("basic", 2'd0, 14, 1'b0, 8'h38, -1, 0, -1);
    fill_bytes(2);
    run_pkt("stall", 2'd1, 8, 1'b0, 8'h21, 5, 3, -1);
    run_pkt("zero", 2'd2, 0, 1'b0, 8'h02, -1, 0, -1);

    cmd_valid = 1'b1;
    cmd_addr  = 2'd3;
    cmd_len   = 6'd5;
    pl_valid  = 1'b1;
    pl_data   = 8'hA5;
    tick();
    cmd_valid = 1'b0;
    cmd_addr  = 2'd0;
    cmd_len   = 6'd0;
    check_eq("illegal_cmd_err", 32'(cmd_err), 32'd1);
    check_eq("illegal_pkt_valid", 32'(pkt_valid), 32'd0);
    check_eq("illegal_pl_ready", 32'(pl_ready), 32'd0);
    check_eq("illegal_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    pl_valid = 1'b0;
    pl_data  = 8'd0;
    check_eq("illegal_cmd_err_pulse", 32'(cmd_err), 32'd0);
    check_eq("illegal_pl_ready2", 32'(pl_ready), 32'd0);
    $display("cmd illegal addr=3 len=5 checks=%0d failures=%0d", checks, failures);

    fill_bytes(3);
    run_pkt("corrupt", 2'd2, 16, 1'b1, 8'h42, 17, 2, -1);
    fill_bytes(4);
    run_pkt("maxlen", 2'd1, 63, 1'b0, 8'hFD, 0, 2, -1);
    fill_bytes(5);
    run_pkt("rstmid", 2'd0, 10, 1'b0, 8'h28, -1, 0, 6);
    fill_bytes(6);
    run_pkt("afterrst", 2'd1, 3, 1'b0, 8'h0D, -1, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
